// File: rtl/aes_sbox_server.sv
// AES S-box responder: forward/inverse tables built by a GF(2^8) generator after reset (or FIPS ROM under AES_SBOX_ROM_EN);
// one registered lookup per cycle, one-cycle latency, no backpressure; lookups before ready_o are ignored and sbox_data_o holds 0x00.
module aes_sbox_server (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] sbox_data_i,
   input  logic       sbox_decrypt_i,
   output logic [7:0] sbox_data_o,
   output logic       ready_o
);

`ifdef AES_SBOX_ROM_EN

   // Byte i of each table lives at bits [(255-i)*8 +: 8].
   localparam logic [2047:0] FWD_ROM = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] INV_ROM = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   always_ff @(posedge clk) begin
      if (reset) begin
         sbox_data_o <= 8'h00;
         ready_o     <= 1'b0;
      end else begin
         ready_o     <= 1'b1;
         sbox_data_o <= sbox_decrypt_i ? INV_ROM[{~sbox_data_i, 3'b000} +: 8]
                                       : FWD_ROM[{~sbox_data_i, 3'b000} +: 8];
      end
   end

`else

   typedef enum logic [1:0] {GEN, ZERO, SERVE} state_t;

   state_t     state, state_nxt;
   logic [7:0] p, q;
   logic [7:0] p_nxt, q_nxt, s_nxt;
   logic [7:0] q_a, q_b, q_c;
   logic [7:0] fwd_mem [256];
   logic [7:0] inv_mem [256];

   // p walks the powers of 3; q tracks its inverse (powers of 3^-1), so q_nxt = 1/p_nxt.
   always_comb begin
      p_nxt = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
      q_a   = q ^ {q[6:0], 1'b0};
      q_b   = q_a ^ {q_a[5:0], 2'b00};
      q_c   = q_b ^ {q_b[3:0], 4'b0000};
      q_nxt = q_c[7] ? (q_c ^ 8'h09) : q_c;
      s_nxt = q_nxt ^ {q_nxt[6:0], q_nxt[7]} ^ {q_nxt[5:0], q_nxt[7:6]}
                    ^ {q_nxt[4:0], q_nxt[7:5]} ^ {q_nxt[3:0], q_nxt[7:4]} ^ 8'h63;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         GEN:     if (p_nxt == 8'h01) state_nxt = ZERO;
         ZERO:    state_nxt = SERVE;
         SERVE:   state_nxt = SERVE;
         default: state_nxt = GEN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= GEN;
         p     <= 8'h01;
         q     <= 8'h01;
      end else begin
         state <= state_nxt;
         if (state == GEN) begin
            p <= p_nxt;
            q <= q_nxt;
         end
      end
   end

   // Zero has no multiplicative inverse, so its entry is patched in after the cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         if (state == GEN) begin
            fwd_mem[p_nxt] <= s_nxt;
            inv_mem[s_nxt] <= p_nxt;
         end else if (state == ZERO) begin
            fwd_mem[8'h00] <= 8'h63;
            inv_mem[8'h63] <= 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sbox_data_o <= 8'h00;
         ready_o     <= 1'b0;
      end else begin
         ready_o <= (state == ZERO) || (state == SERVE);
         if (state == SERVE)
            sbox_data_o <= sbox_decrypt_i ? inv_mem[sbox_data_i] : fwd_mem[sbox_data_i];
         else
            sbox_data_o <= 8'h00;
      end
   end

`endif

endmodule

// File: tb/tb_aes_sbox_server.sv
// Directed bench for aes_sbox_server: ready timing, lookups, one AES SubBytes/ShiftRows round, full sweep, resets.
module tb_aes_sbox_server;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] sbox_data_i = 8'h00;
   logic       sbox_decrypt_i = 1'b0;
   logic [7:0] sbox_data_o;
   logic       ready_o;

   int checks = 0;
   int failures = 0;

`ifdef AES_SBOX_ROM_EN
   localparam int READY_EDGES = 1;
`else
   localparam int READY_EDGES = 256;
`endif

   aes_sbox_server dut (
      .clk            (clk),
      .reset          (reset),
      .sbox_data_i    (sbox_data_i),
      .sbox_decrypt_i (sbox_decrypt_i),
      .sbox_data_o    (sbox_data_o),
      .ready_o        (ready_o)
   );

   always #5 clk = ~clk;

   logic [7:0]    fwd_tab [256];
   logic [2047:0] tab_bits;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic lookup(input logic [7:0] d, input logic dec, output logic [7:0] r);
      @(negedge clk);
      sbox_data_i    = d;
      sbox_decrypt_i = dec;
      @(posedge clk);
      #1 r = sbox_data_o;
   endtask

   // Counts edges after reset release until ready_o rises; flags any non-zero output while not ready.
   task automatic wait_ready(output int n, output int bad);
      n   = 0;
      bad = 0;
      sbox_data_i    = 8'h53;
      sbox_decrypt_i = 1'b0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (ready_o !== 1'b1 && sbox_data_o !== 8'h00) bad++;
      end while (ready_o !== 1'b1 && n < 400);
   endtask

   initial begin
      logic [7:0]   r, r2, xb;
      logic [7:0]   in_b  [16];
      logic [7:0]   sub_b [16];
      logic [7:0]   sh_b  [16];
      logic [127:0] in_blk, out_blk, back_blk;
      int           n, bad;

      tab_bits = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      for (int i = 0; i < 256; i++) fwd_tab[i] = tab_bits[2047 - 8*i -: 8];

      // Reset for three cycles, then time the table build.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_ready", {127'd0, ready_o}, 128'd0);
      chk("reset_data", {120'd0, sbox_data_o}, 128'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready(n, bad);
      chk("ready_edges", n, READY_EDGES);
      chk("data_zero_before_ready", bad, 0);

      // Forward/inverse directed vectors, mode toggling every cycle back to back.
      lookup(8'h00, 1'b0, r); chk("fwd_00", r, 8'h63);
      lookup(8'h63, 1'b1, r); chk("inv_63", r, 8'h00);
      lookup(8'h53, 1'b0, r); chk("fwd_53", r, 8'hED);
      lookup(8'hED, 1'b1, r); chk("inv_ED", r, 8'h53);
      lookup(8'hFF, 1'b0, r); chk("fwd_FF", r, 8'h16);
      lookup(8'h16, 1'b1, r); chk("inv_16", r, 8'hFF);
      lookup(8'h01, 1'b0, r); chk("fwd_01", r, 8'h7C);
      lookup(8'h7C, 1'b1, r); chk("inv_7C", r, 8'h01);

      // Requester emulation: SubBytes then ShiftRows, column-major state.
      in_blk = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
      for (int i = 0; i < 16; i++) in_b[i] = in_blk[127 - 8*i -: 8];
      for (int i = 0; i < 16; i++) begin
         lookup(in_b[i], 1'b0, r);
         sub_b[i] = r;
      end
      chk("ready_during_round", {127'd0, ready_o}, 128'd1);
      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++) sh_b[rr + 4*c] = sub_b[rr + 4*((c + rr) % 4)];
      for (int i = 0; i < 16; i++) out_blk[127 - 8*i -: 8] = sh_b[i];
      chk("aes_subshift_enc", out_blk, 128'hd4bf5d30e0b452aeb84111f11e2798e5);

      for (int c = 0; c < 4; c++)
         for (int rr = 0; rr < 4; rr++) sub_b[rr + 4*((c + rr) % 4)] = out_blk[127 - 8*(rr + 4*c) -: 8];
      for (int i = 0; i < 16; i++) begin
         lookup(sub_b[i], 1'b1, r);
         back_blk[127 - 8*i -: 8] = r;
      end
      chk("aes_subshift_dec", back_blk, in_blk);

      // Exhaustive sweep against the FIPS-197 table plus round trip through the inverse table.
      for (int x = 0; x < 256; x++) begin
         xb = x[7:0];
         lookup(xb, 1'b0, r);
         chk($sformatf("sweep_fwd_%02h", xb), r, fwd_tab[x]);
         lookup(r, 1'b1, r2);
         chk($sformatf("sweep_inv_%02h", xb), r2, xb);
      end

      // Reset while serving clears outputs on that edge.
      lookup(8'h00, 1'b0, r);
      chk("pre_serve_reset_data", r, 8'h63);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("serve_reset_ready", {127'd0, ready_o}, 128'd0);
      chk("serve_reset_data", {120'd0, sbox_data_o}, 128'd0);

      // Reset pulse 100 edges into generation restarts the full count.
      @(negedge clk);
      reset = 1'b0;
      sbox_data_i = 8'h53;
      repeat (100) @(posedge clk);
      #1;
      chk("gen100_ready", {127'd0, ready_o}, (100 >= READY_EDGES) ? 128'd1 : 128'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("gen_reset_ready", {127'd0, ready_o}, 128'd0);
      chk("gen_reset_data", {120'd0, sbox_data_o}, 128'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready(n, bad);
      chk("ready_edges_after_restart", n, READY_EDGES);
      chk("data_zero_after_restart", bad, 0);
      lookup(8'h53, 1'b0, r); chk("post_restart_fwd_53", r, 8'hED);
      lookup(8'h63, 1'b1, r); chk("post_restart_inv_63", r, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
